// File: rtl/pwm_decoder_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : pwm_decoder_pkg                                                  |
// | Brief   : Shared FSM state encoding and parameter defaults for pwm_decoder |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package pwm_decoder_pkg;

    localparam int c_cnt_width_def   = 16;
    localparam int c_sync_stages_def = 2;
    localparam int c_filt_len_def    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_edge_det.sv
// +----------------------------------------------------------------------------+
// | Module  : pwm_edge_det                                                     |
// | Brief   : in_dig synchronizer, optional glitch filter (compiled in by      |
// |           PWM_DECODER_GLITCH_FILTER_EN) and one-cycle rise/fall pulses     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module pwm_edge_det
    import pwm_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = c_sync_stages_def,
    parameter int FILT_LEN    = c_filt_len_def
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in_dig,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_clean;
    logic                   r_prev;

    if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_param_check
        $error("pwm_edge_det: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in_dig};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    localparam int c_filt_cw = $clog2(FILT_LEN + 1);

    logic [c_filt_cw-1:0] r_filt_cnt;
    logic                 r_filt;

    // Output flips only on the FILT_LEN-th consecutive sample that disagrees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt     <= 1'b0;
            r_filt_cnt <= '0;
        end else if (w_sync == r_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == c_filt_cw'(FILT_LEN - 1)) begin
            r_filt     <= w_sync;
            r_filt_cnt <= '0;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_clean = r_filt;
`else
    assign w_clean = w_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_clean;
        end
    end

    assign o_rise = w_clean & ~r_prev;
    assign o_fall = ~w_clean & r_prev;

endmodule

`default_nettype wire

// File: rtl/pwm_decoder.sv
// +----------------------------------------------------------------------------+
// | Module  : pwm_decoder                                                      |
// | Brief   : Measures high time and period of an asynchronous PWM input.      |
// |           Glitch filter compiled in by PWM_DECODER_GLITCH_FILTER_EN.       |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module pwm_decoder
    import pwm_decoder_pkg::*;
#(
    parameter int CNT_WIDTH   = c_cnt_width_def,
    parameter int SYNC_STAGES = c_sync_stages_def,
    parameter int FILT_LEN    = c_filt_len_def
) (
    input  logic                 emu_clk,
    input  logic                 emu_rst_n,
    input  logic                 en,
    input  logic                 in_dig,
    output logic [CNT_WIDTH-1:0] high_cnt,
    output logic [CNT_WIDTH-1:0] period_cnt,
    output logic                 meas_valid,
    output logic                 timeout
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    logic w_rise;
    logic w_fall;

    state_t               r_state,  w_state_nxt;
    logic [CNT_WIDTH-1:0] r_hcnt,   w_hcnt_nxt;
    logic [CNT_WIDTH-1:0] r_pcnt,   w_pcnt_nxt;
    logic [CNT_WIDTH-1:0] r_high,   w_high_nxt;
    logic [CNT_WIDTH-1:0] r_period, w_period_nxt;
    logic                 r_meas,   w_meas_nxt;
    logic                 r_to,     w_to_nxt;
    logic [CNT_WIDTH-1:0] w_pcnt_inc;
    logic                 w_sat;

    pwm_edge_det #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_edge_det (
        .clk      (emu_clk),
        .rst_n    (emu_rst_n),
        .i_in_dig (in_dig),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    // Saturation is flagged on the cycle whose increment would land on the max.
    assign w_pcnt_inc = r_pcnt + 1'b1;
    assign w_sat      = (w_pcnt_inc == c_cnt_max);

    always_comb begin
        w_state_nxt  = r_state;
        w_hcnt_nxt   = r_hcnt;
        w_pcnt_nxt   = r_pcnt;
        w_high_nxt   = r_high;
        w_period_nxt = r_period;
        w_meas_nxt   = 1'b0;
        w_to_nxt     = 1'b0;

        if (!en) begin
            w_state_nxt = IDLE;
            w_hcnt_nxt  = '0;
            w_pcnt_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = ARM;
                end
                ARM: begin
                    if (w_rise) begin
                        w_state_nxt = HIGH;
                        w_hcnt_nxt  = c_cnt_one;
                        w_pcnt_nxt  = c_cnt_one;
                    end
                end
                HIGH: begin
                    if (w_sat) begin
                        w_state_nxt = ARM;
                        w_to_nxt    = 1'b1;
                        w_hcnt_nxt  = '0;
                        w_pcnt_nxt  = '0;
                    end else begin
                        w_pcnt_nxt = w_pcnt_inc;
                        if (w_fall) begin
                            w_state_nxt = LOW;
                        end else begin
                            w_hcnt_nxt = r_hcnt + 1'b1;
                        end
                    end
                end
                LOW: begin
                    // A completed period wins over a coincident saturation.
                    if (w_rise) begin
                        w_state_nxt  = HIGH;
                        w_high_nxt   = r_hcnt;
                        w_period_nxt = r_pcnt;
                        w_meas_nxt   = 1'b1;
                        w_hcnt_nxt   = c_cnt_one;
                        w_pcnt_nxt   = c_cnt_one;
                    end else if (w_sat) begin
                        w_state_nxt = ARM;
                        w_to_nxt    = 1'b1;
                        w_hcnt_nxt  = '0;
                        w_pcnt_nxt  = '0;
                    end else begin
                        w_pcnt_nxt = w_pcnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            r_state  <= IDLE;
            r_hcnt   <= '0;
            r_pcnt   <= '0;
            r_high   <= '0;
            r_period <= '0;
            r_meas   <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hcnt   <= w_hcnt_nxt;
            r_pcnt   <= w_pcnt_nxt;
            r_high   <= w_high_nxt;
            r_period <= w_period_nxt;
            r_meas   <= w_meas_nxt;
            r_to     <= w_to_nxt;
        end
    end

    assign high_cnt   = r_high;
    assign period_cnt = r_period;
    assign meas_valid = r_meas;
    assign timeout    = r_to;

endmodule

`default_nettype wire

// File: tb/tb_pwm_decoder.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_pwm_decoder                                                   |
// | Brief   : Directed self-checking bench for pwm_decoder (CNT_WIDTH=8);      |
// |           expectations follow PWM_DECODER_GLITCH_FILTER_EN if defined      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pwm_decoder;

    localparam int c_cw = 8;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    localparam int c_flt       = 4;
    localparam int c_gl_n      = 3;
    localparam int c_gl_h1     = 40;
    localparam int c_gl_p1     = 100;
    localparam int c_gl_h2     = 40;
    localparam int c_gl_p2     = 100;
`else
    localparam int c_flt       = 0;
    localparam int c_gl_n      = 4;
    localparam int c_gl_h1     = 40;
    localparam int c_gl_p1     = 60;
    localparam int c_gl_h2     = 2;
    localparam int c_gl_p2     = 40;
`endif
    // Input drive to visible meas_valid: 2 sync flops + detect + output register.
    localparam int c_lat       = 3 + c_flt;
    // Input drive to visible timeout: pcnt=1 appears c_lat after the drive,
    // and 254 cycles later the increment would reach 255.
    localparam int c_to_lat    = 257 + c_flt;

    logic            emu_clk;
    logic            emu_rst_n;
    logic            en;
    logic            in_dig;
    logic [c_cw-1:0] high_cnt;
    logic [c_cw-1:0] period_cnt;
    logic            meas_valid;
    logic            timeout;

    int total;
    int bad;
    int cyc;
    int n_mv;
    int n_to;
    int mv_cyc;
    int to_cyc;
    int rise_cyc;
    int mv_h [16];
    int mv_p [16];

    pwm_decoder #(
        .CNT_WIDTH   (c_cw),
        .SYNC_STAGES (2),
        .FILT_LEN    (4)
    ) dut (
        .emu_clk    (emu_clk),
        .emu_rst_n  (emu_rst_n),
        .en         (en),
        .in_dig     (in_dig),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .meas_valid (meas_valid),
        .timeout    (timeout)
    );

    initial emu_clk = 1'b0;
    always #5 emu_clk = ~emu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge emu_clk);
        #1;
        cyc++;
        if (meas_valid === 1'b1) begin
            if (n_mv < 16) begin
                mv_h[n_mv] = int'(high_cnt);
                mv_p[n_mv] = int'(period_cnt);
            end
            mv_cyc = cyc;
            n_mv++;
        end
        if (timeout === 1'b1) begin
            to_cyc = cyc;
            n_to++;
        end
    endtask

    task automatic hold(input logic v, input int n);
        in_dig = v;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pwm(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            rise_cyc = cyc;
            hold(1'b1, hi);
            hold(1'b0, lo);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; n_mv = 0; n_to = 0;
        mv_cyc = 0; to_cyc = 0; rise_cyc = 0;
        emu_rst_n = 1'b0; en = 1'b0; in_dig = 1'b0;

        // Reset state
        for (int i = 0; i < 3; i++) step();
        chk("rst_high_cnt",   32'(high_cnt),   0);
        chk("rst_period_cnt", 32'(period_cnt), 0);
        chk("rst_meas_valid", 32'(meas_valid), 0);
        chk("rst_timeout",    32'(timeout),    0);
        emu_rst_n = 1'b1;
        en        = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Steady 50/100: four rises give three measurements
        n_mv = 0; n_to = 0;
        pwm(50, 50, 4);
        chk("s50_count",   n_mv, 3);
        chk("s50_h0",      mv_h[0], 50);
        chk("s50_p0",      mv_p[0], 100);
        chk("s50_h2",      mv_h[2], 50);
        chk("s50_p2",      mv_p[2], 100);
        chk("s50_latency", mv_cyc - rise_cyc, c_lat);
        chk("s50_no_to",   n_to, 0);

        // Duty change to 25/100: first rise closes the last 50/100 period
        n_mv = 0;
        pwm(25, 75, 2);
        chk("d25_count", n_mv, 2);
        chk("d25_h0",    mv_h[0], 50);
        chk("d25_h1",    mv_h[1], 25);
        chk("d25_p1",    mv_p[1], 100);

        // en dropped during HIGH, with a rising edge inside the gap
        n_mv = 0;
        hold(1'b1, 10);
        chk("en_pre_count", n_mv, 1);
        en = 1'b0;
        hold(1'b1, 4);
        hold(1'b0, 3);
        hold(1'b1, 3);
        chk("en_gap_count",  n_mv, 1);
        chk("en_gap_high",   32'(high_cnt),   25);
        chk("en_gap_period", 32'(period_cnt), 100);
        en = 1'b1;
        hold(1'b1, 30);
        hold(1'b0, 50);
        pwm(40, 60, 2);
        chk("en_after_count", n_mv, 2);
        chk("en_after_h",     mv_h[1], 40);
        chk("en_after_p",     mv_p[1], 100);

        // Asynchronous reset in the middle of a LOW phase
        n_mv = 0;
        hold(1'b1, 40);
        hold(1'b0, 30);
        emu_rst_n = 1'b0;
        #1;
        chk("mrst_high_cnt",   32'(high_cnt),   0);
        chk("mrst_period_cnt", 32'(period_cnt), 0);
        chk("mrst_meas_valid", 32'(meas_valid), 0);
        chk("mrst_timeout",    32'(timeout),    0);
        step();
        step();
        emu_rst_n = 1'b1;
        n_mv = 0;
        hold(1'b0, 30);
        pwm(40, 60, 1);
        chk("mrst_one_rise", n_mv, 0);
        pwm(40, 60, 1);
        chk("mrst_two_rise", n_mv, 1);
        chk("mrst_h",        mv_h[0], 40);
        chk("mrst_p",        mv_p[0], 100);

        // Timeout: one rise from ARM, then held low
        en = 1'b0;
        step(); step();
        en = 1'b1;
        step(); step();
        n_mv = 0; n_to = 0;
        rise_cyc = cyc;
        hold(1'b1, 5);
        hold(1'b0, 295);
        chk("to_count",  n_to, 1);
        chk("to_delay",  to_cyc - rise_cyc, c_to_lat);
        chk("to_no_mv",  n_mv, 0);
        chk("to_high",   32'(high_cnt),   40);
        chk("to_period", 32'(period_cnt), 100);
        pwm(30, 70, 2);
        chk("to_rearm_count", n_mv, 1);
        chk("to_rearm_h",     mv_h[0], 30);
        chk("to_rearm_p",     mv_p[0], 100);

        // 2-cycle glitch inside the low phase of a 40/100 waveform
        n_mv = 0;
        hold(1'b1, 40);
        hold(1'b0, 20);
        hold(1'b1, 2);
        hold(1'b0, 38);
        pwm(40, 60, 2);
        chk("gl_count", n_mv, c_gl_n);
        chk("gl_h1",    mv_h[1], c_gl_h1);
        chk("gl_p1",    mv_p[1], c_gl_p1);
        chk("gl_h2",    mv_h[2], c_gl_h2);
        chk("gl_p2",    mv_p[2], c_gl_p2);
        chk("gl_last_h", 32'(high_cnt),   40);
        chk("gl_last_p", 32'(period_cnt), 100);

        // Rise coincides with saturation in LOW: measurement wins
        n_mv = 0; n_to = 0;
        hold(1'b1, 100);
        hold(1'b0, 154);
        hold(1'b1, 10);
        chk("sat_count", n_mv, 2);
        chk("sat_h",     mv_h[1], 100);
        chk("sat_p",     mv_p[1], 254);
        chk("sat_no_to", n_to, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
